// File: rtl/sequence_output_collector.sv
// Reassembles the serial sorter stream into N-word parallel frames, checks frame order,
// and buffers up to two finished frames behind a valid/ready output.
module sequence_output_collector_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module sequence_output_collector #(
  parameter int DW     = 8,
  parameter int N      = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_frame,
  output logic            out_sorted,
  output logic            err_short,
  output logic            err_long,
  input  logic            clr_err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0]             idx;
  logic [DW-1:0]             prev;
  logic                      run_sorted;
  logic [N-1:0][DW-1:0]      assembly;
  logic [N-1:0][DW-1:0]      frame_in;
  logic [1:0][N-1:0][DW-1:0] mem;
  logic [1:0]                mem_sorted;
  logic                      wp, rp;
  logic [1:0]                cnt;
  logic accept, at_end, push, pop, lt, word_ok, sorted_now;

  assign in_ready   = (cnt < 2'd2);
  assign out_valid  = (cnt != 2'd0);
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign at_end     = (idx == LAST_IDX);
  assign push       = accept & at_end & in_last;

  generate
    if (SIGNED) begin : g_signed
      assign lt = $signed(in_data) < $signed(prev);
    end else begin : g_unsigned
      assign lt = in_data < prev;
    end
  endgenerate

  // The first word of a frame has no predecessor and is always in order.
  assign word_ok    = (idx == '0) | ~lt;
  assign sorted_now = run_sorted & word_ok;

  // One slot register per word; the final word bypasses its slot so the
  // completed frame can be pushed on the same transfer.
  generate
    for (genvar k = 0; k < N; k++) begin : g_slot
      sequence_output_collector_slot #(.DW(DW)) u_slot (
        .clk  (clk),
        .rst  (rst),
        .load (accept && (idx == IW'(k))),
        .d    (in_data),
        .q    (assembly[k])
      );
      assign frame_in[k] = (idx == IW'(k)) ? in_data : assembly[k];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      prev       <= '0;
      run_sorted <= 1'b1;
    end else if (accept) begin
      prev <= in_data;
      if (in_last || at_end) begin
        idx        <= '0;
        run_sorted <= 1'b1;
      end else begin
        idx        <= idx + IW'(1);
        run_sorted <= sorted_now;
      end
    end
  end

  // Sticky errors: a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (accept && in_last && !at_end) err_short <= 1'b1;
      else if (clr_err)                 err_short <= 1'b0;
      if (accept && at_end && !in_last) err_long <= 1'b1;
      else if (clr_err)                 err_long <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem        <= '0;
      mem_sorted <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= '0;
    end else begin
      if (push) begin
        mem[wp]        <= frame_in;
        mem_sorted[wp] <= sorted_now;
        wp             <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign out_frame  = mem[rp];
  assign out_sorted = out_valid & mem_sorted[rp];
endmodule

// File: tb/tb_sequence_output_collector.sv
// Bench for sequence_output_collector: unsigned and signed instances share stimulus;
// expected frames queue up as they are sent and are checked as the DUTs present them.
module tb_sequence_output_collector;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready, clr_err;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_sorted, err_short, err_long;
  logic [31:0] out_frame;
  logic        in_ready_s, out_valid_s, out_sorted_s, err_short_s, err_long_s;
  logic [31:0] out_frame_s;

  always #5 clk = ~clk;

  sequence_output_collector #(.DW(8), .N(4), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
    .out_sorted(out_sorted), .err_short(err_short), .err_long(err_long), .clr_err(clr_err));

  sequence_output_collector #(.DW(8), .N(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_frame(out_frame_s),
    .out_sorted(out_sorted_s), .err_short(err_short_s), .err_long(err_long_s), .clr_err(clr_err));

  typedef struct {
    logic [7:0]  w0, w1, w2, w3;
    logic [31:0] frame;
    logic        su, ss;
  } vec_t;

  typedef struct {
    logic [31:0] frame;
    logic        su, ss;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   checks = 0, failures = 0, pops = 0, pushes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Head entry is compared every cycle it is presented, which also covers
  // stability under backpressure; it is retired only on a transfer.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%0h required=none", out_frame);
      end else begin
        chk("frame_u", out_frame, sb[0].frame);
        chk("sorted_u", {31'd0, out_sorted}, {31'd0, sb[0].su});
        chk("frame_s", out_frame_s, sb[0].frame);
        chk("sorted_s", {31'd0, out_sorted_s}, {31'd0, sb[0].ss});
        if (out_ready) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input bit lat_chk);
    send(v.w0, 1'b0);
    send(v.w1, 1'b0);
    send(v.w2, 1'b0);
    if (lat_chk) chk("valid_before_last", {31'd0, out_valid}, 32'd0);
    send(v.w3, 1'b1);
    sb.push_back('{v.frame, v.su, v.ss});
    pushes++;
    if (lat_chk) chk("valid_after_last", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'd3,   8'd7,   8'd7,   8'd200, 32'hC8070703, 1'b1, 1'b0};
    tbl[1] = '{8'd9,   8'd2,   8'd5,   8'd1,   32'h01050209, 1'b0, 1'b0};
    tbl[2] = '{8'hF0,  8'h00,  8'h05,  8'h7F,  32'h7F0500F0, 1'b0, 1'b1};
    tbl[3] = '{8'h80,  8'hFF,  8'h00,  8'h7F,  32'h7F00FF80, 1'b0, 1'b1};
    tbl[4] = '{8'd5,   8'd5,   8'd5,   8'd5,   32'h05050505, 1'b1, 1'b1};
    tbl[5] = '{8'd4,   8'd5,   8'd6,   8'd7,   32'h07060504, 1'b1, 1'b1};
    tbl[6] = '{8'd10,  8'd20,  8'd30,  8'd40,  32'h281E140A, 1'b1, 1'b1};
    tbl[7] = '{8'hFF,  8'hFE,  8'hFE,  8'hFF,  32'hFFFEFEFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_frame", out_frame, 32'd0);
    chk("rst_out_sorted", {31'd0, out_sorted}, 32'd0);
    chk("rst_errs", {30'd0, err_short, err_long}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming frames with the consumer always ready; first one checks latency.
    for (int i = 0; i < 5; i++) send_frame(tbl[i], i == 0);
    drain();
    chk("no_errs", {30'd0, err_short, err_long}, 32'd0);

    // Short frame dropped, followed by a good frame.
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    chk("err_short_set", {30'd0, err_short, err_long}, 32'd2);
    send_frame(tbl[5], 1'b0);
    drain();
    chk("err_short_sticky", {31'd0, err_short}, 32'd1);
    pulse_clr();
    chk("err_short_clr", {31'd0, err_short}, 32'd0);

    // Long frame with clear held high: the set must win.
    clr_err = 1'b1;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    clr_err = 1'b0;
    chk("err_long_set", {30'd0, err_short, err_long}, 32'd1);
    send_frame(tbl[2], 1'b0);
    drain();
    pulse_clr();
    chk("err_long_clr", {31'd0, err_long}, 32'd0);

    // Backpressure: two frames fill the buffer, the third stalls until released.
    out_ready = 1'b0;
    fork
      begin
        send_frame(tbl[1], 1'b0);
        send_frame(tbl[7], 1'b0);
        send_frame(tbl[4], 1'b0);
      end
      begin
        repeat (20) @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_buffered", 32'(sb.size()), 32'd2);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with one frame buffered and a partial frame in flight.
    out_ready = 1'b0;
    send_frame(tbl[3], 1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_frame", out_frame, 32'd0);
    pushes = pushes - sb.size();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_frame(tbl[6], 1'b0);
    drain();

    chk("frame_count", 32'(pops), 32'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sequence_output_collector.md
Name: sequence_output_collector

Overview:
Receiving end of the sequence sorter datapath. Accepts the serial word stream leaving the comparator chain, one word per handshake, and reassembles each N-word frame into a parallel word. It checks that the frame arrived in non-decreasing order and buffers up to two completed frames for a downstream consumer with valid/ready flow control. Framing violations are reported through sticky error flags.

Parameters:
DW, 8, data word width in bits
N, 4, words per frame (legal range 2..16)
SIGNED, 0, 0 = unsigned order check, 1 = two's-complement order check

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word present
in_ready  output  1  collector can accept a word
in_data  input  DW  serial word from the sorter chain
in_last  input  1  marks the final word of a frame
out_valid  output  1  head of frame buffer is valid
out_ready  input  1  consumer accepts the head frame
out_frame  output  N*DW  word 0 in bits [DW-1:0], word k in bits [(k+1)*DW-1:k*DW]
out_sorted  output  1  head frame was non-decreasing (valid with out_valid)
err_short  output  1  sticky: in_last seen before word N-1
err_long  output  1  sticky: word N-1 accepted without in_last
clr_err  input  1  synchronous clear of both sticky errors

Behaviour:
- Reset, asynchronous: the word index is 0, the assembly register is 0, the running-sorted flag is 1, and the frame buffer is empty. Outputs go to out_valid=0, out_frame=0, out_sorted=0, err_short=0, err_long=0, in_ready=1.
- An input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- in_ready = (registered buffer count < 2). It does not depend combinationally on out_ready.
- Assembly: an accepted word goes into slot idx of the assembly register, and idx increments.
- Order check:
  - For idx>0, compare the accepted word with the previously accepted word, unsigned or signed per SIGNED.
  - If the new word is less than the previous word, clear the running-sorted flag.
  - Equal values count as sorted.
- Frame completion happens on the transfer where idx==N-1 and in_last==1:
  - The N words plus the final sorted flag are pushed into the 2-entry FIFO.
  - idx returns to 0 and the sorted flag returns to 1.
  - out_valid rises on the next cycle, a latency of 1 clk after the last word.
- Short frame (in_last==1 with idx<N-1):
  - The partial frame is discarded and err_short is set.
  - idx returns to 0, the sorted flag returns to 1, and nothing is pushed.
- Long frame (idx==N-1 with in_last==0):
  - The frame is discarded, err_long is set, and idx returns to 0.
  - The next word starts a new frame.
- FIFO: 2 entries with circular read and write pointers and a 2-bit count.
  - A push and a pop in the same cycle leave the count unchanged. This is legal at count 1. At count 2 no push can occur because in_ready=0.
  - A pop from an empty FIFO is impossible because out_valid=0.
- Output stability: out_frame and out_sorted come from the head entry and hold stable while out_valid=1 and out_ready=0.
- Sticky errors:
  - err_short and err_long stay set until clr_err=1.
  - If clr_err and a new error event occur in the same cycle, set wins.
- Reset mid-frame drops both the partial frame and the buffered frames immediately.

Test Plan:
1. DW=8, N=4, out_ready=1. Send 3,7,7,200 with in_last on 200. Required: out_valid 1 cycle later, out_frame=0xC8070703, out_sorted=1, no errors.
2. Send 9,2,5,1 (last on 1). Required: out_frame=0x01050209, out_sorted=0.
3. Send 1,2 with in_last on 2, then 4,5,6,7 (last on 7). Required: err_short=1, exactly one frame out, out_frame=0x07060504. Then pulse clr_err and check err_short=0.
4. Hold out_ready=0 and send 3 valid frames back-to-back. Required: in_ready falls after the 2nd frame completes and the 3rd frame's words stall. Release out_ready: frames drain in order, the 3rd frame is accepted, and no data is lost.
5. Assert rst mid-frame after 2 words, with 1 frame buffered. Required: out_valid=0 immediately (asynchronous). The next full frame 10,20,30,40 outputs 0x281E140A.
6. SIGNED=1. Send 0xF0,0x00,0x05,0x7F. Required: out_sorted=1, since -16 ≤ 0 ≤ 5 ≤ 127. With SIGNED=0 the same frame gives out_sorted=0.
